input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 16 +
 rtl/input_conditioner_debouncer.sv | 49 ++++
 rtl/input_conditioner.sv | 75 +++++++
 tb/tb_input_conditioner.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared traffic-controller constants: light codes and the default debounce time.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    LIGHT_OFF    = 2'd0,
    LIGHT_GREEN  = 2'd1,
    LIGHT_YELLOW = 2'd2,
    LIGHT_RED    = 2'd3
  } light_e;

  // 10 ms at 100 MHz
  localparam int unsigned DEB_CYCLES_DEFAULT = 1000000;

  localparam int unsigned WALK_COUNT_W = 8;

endpackage

// File: rtl/input_conditioner_debouncer.sv
// Two-flop synchronizer followed by a counter-based debouncer for one raw board input.
module debouncer
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while s2 disagrees; any agreement or a level change clears it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the side-road sensor and pedestrian button for the traffic controller,
// holding walk requests until the controller acknowledges with a walk_light rising edge.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sensor_raw,
  input  logic                    walk_raw,
  input  logic                    walk_light,
  output logic                    sensor,
  output logic                    walk,
  output logic [WALK_COUNT_W-1:0] walk_count
);

  logic                    sensor_level;
  logic                    walk_level;
  logic                    walk_level_q;
  logic                    walk_light_q;
  logic                    walk_pending_q, walk_pending_d;
  logic [WALK_COUNT_W-1:0] walk_count_q, walk_count_d;
  logic                    press;
  logic                    ack;

  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_sensor_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (sensor_raw),
    .level (sensor_level)
  );

  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_walk_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (walk_raw),
    .level (walk_level)
  );

  // A press arriving with the acknowledge wins, so the request is never lost.
  always_comb begin
    press          = walk_level & ~walk_level_q;
    ack            = walk_light & ~walk_light_q;
    walk_pending_d = walk_pending_q;
    walk_count_d   = walk_count_q;
    if (press) begin
      walk_pending_d = 1'b1;
    end else if (ack) begin
      walk_pending_d = 1'b0;
    end
    if (press && (walk_count_q != '1)) begin
      walk_count_d = walk_count_q + WALK_COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      walk_level_q   <= 1'b0;
      walk_light_q   <= 1'b0;
      walk_pending_q <= 1'b0;
      walk_count_q   <= '0;
    end else begin
      walk_level_q   <= walk_level;
      walk_light_q   <= walk_light;
      walk_pending_q <= walk_pending_d;
      walk_count_q   <= walk_count_d;
    end
  end

  assign sensor     = sensor_level;
  assign walk       = walk_pending_q;
  assign walk_count = walk_count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a sample-window reference model predicts the
// outputs after every clock edge and a negedge monitor compares them against the DUT.
module tb_input_conditioner;

  localparam int unsigned DEB   = 4;
  localparam int unsigned LIMIT = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_raw = 1'b0;
  logic       walk_raw = 1'b0;
  logic       walk_light = 1'b0;
  logic       sensor;
  logic       walk;
  logic [7:0] walk_count;

  always #5 clk = ~clk;

  input_conditioner #(.DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_raw (sensor_raw),
    .walk_raw   (walk_raw),
    .walk_light (walk_light),
    .sensor     (sensor),
    .walk       (walk),
    .walk_count (walk_count)
  );

  typedef struct packed {
    logic       sensor;
    logic       walk;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic done = 1'b0;

  // Reference model: raw samples taken at each edge, newest at bit DEB.
  // A level flips when the DEB samples ending two edges ago all disagree with it.
  logic [DEB:0] m_hs, m_hw;
  logic         m_ls, m_lw, m_lw_prev, m_wl_prev, m_pend;
  int unsigned  m_cnt;

  task automatic model_edge();
    logic press, ack;
    if (reset) begin
      m_hs = '0; m_hw = '0;
      m_ls = 1'b0; m_lw = 1'b0; m_lw_prev = 1'b0; m_wl_prev = 1'b0;
      m_pend = 1'b0; m_cnt = 0;
    end else begin
      press = m_lw && !m_lw_prev;
      ack   = walk_light && !m_wl_prev;
      if (press) m_pend = 1'b1;
      else if (ack) m_pend = 1'b0;
      if (press && m_cnt < 255) m_cnt = m_cnt + 1;
      m_lw_prev = m_lw;
      m_wl_prev = walk_light;
      if (m_hs[DEB-1:0] == {DEB{~m_ls}}) m_ls = ~m_ls;
      if (m_hw[DEB-1:0] == {DEB{~m_lw}}) m_lw = ~m_lw;
      m_hs = {sensor_raw, m_hs[DEB:1]};
      m_hw = {walk_raw, m_hw[DEB:1]};
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.sensor = m_ls;
    e.walk   = m_pend;
    e.cnt    = 8'(m_cnt);
    sb.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int unsigned cyc = 0;
  exp_t        me;

  always @(negedge clk) begin
    cyc++;
    if (sb.size() != 0) begin
      me = sb.pop_front();
      chk("sensor", int'(sensor), int'(me.sensor));
      chk("walk", int'(walk), int'(me.walk));
      chk("walk_count", int'(walk_count), int'(me.cnt));
    end else if (done) begin
      chk("final_walk_count_saturated", int'(walk_count), 255);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
    if (cyc > LIMIT) begin
      errors++;
      $display("FAIL timeout: got %0d cycles expected at most %0d", cyc, LIMIT);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "bench cycle budget exceeded");
    end
  end

  initial begin
    // Reset with both raw inputs already high, then release.
    reset = 1'b1; sensor_raw = 1'b1; walk_raw = 1'b1; walk_light = 1'b0;
    run(3);
    reset = 1'b0;
    run(10);
    sensor_raw = 1'b0; walk_raw = 1'b0;
    run(10);

    // Glitch back to the debounced level restarts the count.
    sensor_raw = 1'b1; run(3);
    sensor_raw = 1'b0; run(1);
    sensor_raw = 1'b1; run(10);
    sensor_raw = 1'b0; run(10);

    // Walk handshake, then walk_light held high.
    walk_raw = 1'b1; run(8);
    walk_raw = 1'b0; run(4);
    walk_light = 1'b1; run(20);
    walk_light = 1'b0; run(5);

    // Collision: press edge and walk_light rising edge on the same clock edge.
    walk_raw = 1'b1; run(8);
    walk_raw = 1'b0; run(10);
    walk_raw = 1'b1; run(6);
    walk_light = 1'b1; run(6);
    walk_light = 1'b0; walk_raw = 1'b0; run(10);

    // Reset in the middle of a debounce.
    walk_raw = 1'b1; run(3);
    reset = 1'b1; run(1);
    reset = 1'b0; run(12);
    walk_raw = 1'b0; walk_light = 1'b1; run(1);
    walk_light = 1'b0; run(8);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) sensor_raw = ~sensor_raw;
      if ($urandom_range(9) == 0) walk_raw = ~walk_raw;
      if ($urandom_range(11) == 0) walk_light = ~walk_light;
      reset = ($urandom_range(199) == 0);
      step();
    end
    reset = 1'b1; run(1);
    reset = 1'b0; sensor_raw = 1'b0; walk_raw = 1'b0; walk_light = 1'b0;

    // Saturation: 260 clean presses.
    for (int p = 0; p < 260; p++) begin
      walk_raw = 1'b1; run(8);
      walk_raw = 1'b0; run(8);
    end
    run(4);
    done = 1'b1;
  end

endmodule
